// File: rtl/blood_pkg.sv
// Shared types and constants for the blood-splatter animation controller.
package blood_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int          SPRITE_DIM  = 64;
  localparam int          ROM_AW      = $clog2(SPRITE_DIM);
  localparam logic [11:0] TRANSPARENT = 12'h000;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Halve each 4-bit RGB channel.
  function automatic logic [11:0] half_bright(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/blood_window.sv
// Maps the scan pixel onto the 64x64 sprite placed at the latched origin.
module blood_window
  import blood_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic [X_W-1:0]    org_x,
  input  logic [Y_W-1:0]    org_y,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ROM_AW-1:0] rom_row,
  output logic [ROM_AW-1:0] rom_col,
  output logic              in_win
);

  logic [X_W:0] w_dx;
  logic [Y_W:0] w_dy;

  assign w_dx = {1'b0, x} - {1'b0, org_x};
  assign w_dy = {1'b0, y} - {1'b0, org_y};

  // Upper bits all zero means non-negative and below 64; left/top of origin never wraps in.
  assign in_win  = (w_dx[X_W:ROM_AW] == '0) && (w_dy[Y_W:ROM_AW] == '0);
  assign rom_col = w_dx[ROM_AW-1:0];
  assign rom_row = w_dy[ROM_AW-1:0];

endmodule

// File: rtl/blood_anim_ctrl.sv
// Blood-splatter frame sequencer and pixel keying; define BLOOD_FADE_EN to
// halve the colour brightness while the last frame is held.
module blood_anim_ctrl
  import blood_pkg::*;
#(
  parameter int NUM_FRAMES      = 25,
  parameter int TICKS_PER_FRAME = 2,
  parameter int HOLD_TICKS      = 30,
  parameter int X_W             = 10,
  parameter int Y_W             = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger,
  input  logic [X_W-1:0]                hit_x,
  input  logic [Y_W-1:0]                hit_y,
  input  logic                          frame_tick,
  input  logic                          video_on,
  input  logic [X_W-1:0]                x,
  input  logic [Y_W-1:0]                y,
  input  logic [11:0]                   color_in,
  output logic [ROM_AW-1:0]             rom_row,
  output logic [ROM_AW-1:0]             rom_col,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_sel,
  output logic                          blood_on,
  output logic [11:0]                   color_out,
  output logic                          busy,
  output logic                          done
);

  localparam int FS_W = $clog2(NUM_FRAMES);
  localparam int TK_W = cnt_w(TICKS_PER_FRAME);
  localparam int HD_W = cnt_w(HOLD_TICKS);

  state_t          r_state;
  logic [FS_W-1:0] r_frame_sel;
  logic [X_W-1:0]  r_org_x;
  logic [Y_W-1:0]  r_org_y;
  logic [TK_W-1:0] r_tick_cnt;
  logic [HD_W-1:0] r_hold_cnt;
  logic            r_done;
  logic            r_in_win;
  logic            r_video_on;
  logic            r_active;
  logic            w_in_win;
  logic            w_blood_on;

  blood_window #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_window (
    .org_x  (r_org_x),
    .org_y  (r_org_y),
    .x      (x),
    .y      (y),
    .rom_row(rom_row),
    .rom_col(rom_col),
    .in_win (w_in_win)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_frame_sel <= '0;
      r_org_x     <= '0;
      r_org_y     <= '0;
      r_tick_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (trigger) begin
        // A hit restarts from any state; a coincident frame_tick is dropped.
        r_state     <= PLAY;
        r_org_x     <= hit_x;
        r_org_y     <= hit_y;
        r_frame_sel <= '0;
        r_tick_cnt  <= '0;
        r_hold_cnt  <= '0;
      end else if (frame_tick) begin
        case (r_state)
          PLAY: begin
            if (r_tick_cnt == TK_W'(TICKS_PER_FRAME - 1)) begin
              r_tick_cnt <= '0;
              if (r_frame_sel == FS_W'(NUM_FRAMES - 1)) begin
                r_state    <= HOLD;
                r_hold_cnt <= '0;
              end else begin
                r_frame_sel <= r_frame_sel + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (r_hold_cnt == HD_W'(HOLD_TICKS - 1)) begin
              r_state     <= IDLE;
              r_frame_sel <= '0;
              r_done      <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Window/video/active terms delayed one cycle to meet the ROM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_win   <= 1'b0;
      r_video_on <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_in_win   <= w_in_win;
      r_video_on <= video_on;
      r_active   <= (r_state != IDLE);
    end
  end

  assign w_blood_on = r_in_win && r_video_on && r_active && (color_in != TRANSPARENT);

`ifdef BLOOD_FADE_EN
  logic r_fade;

  always_ff @(posedge clk) begin
    if (reset) r_fade <= 1'b0;
    else       r_fade <= (r_state == HOLD);
  end

  assign color_out = !w_blood_on ? TRANSPARENT
                   : (r_fade ? half_bright(color_in) : color_in);
`else
  assign color_out = w_blood_on ? color_in : TRANSPARENT;
`endif

  assign blood_on  = w_blood_on;
  assign frame_sel = r_frame_sel;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_blood_anim_ctrl.sv
// Directed self-checking bench for blood_anim_ctrl with a pixel scoreboard.
module tb_blood_anim_ctrl;

  logic        clk = 1'b0;
  logic        reset, trigger, frame_tick, video_on;
  logic [9:0]  hit_x, hit_y, x, y;
  logic [11:0] color_in;
  logic [5:0]  rom_row, rom_col;
  logic [4:0]  frame_sel;
  logic        blood_on, busy, done;
  logic [11:0] color_out;

  blood_anim_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .frame_tick(frame_tick),
    .video_on  (video_on),
    .x         (x),
    .y         (y),
    .color_in  (color_in),
    .rom_row   (rom_row),
    .rom_col   (rom_col),
    .frame_sel (frame_sel),
    .blood_on  (blood_on),
    .color_out (color_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        on;
    logic [11:0] col;
    int          px;
    int          py;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          org_x    = 0;
  int          org_y    = 0;
  bit          exp_busy = 1'b0;
  bit          exp_hold = 1'b0;
  logic [11:0] pend     = 12'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] dim(input logic [11:0] c);
    int r, g, b;
    r = (int'(c) >> 8) & 15;
    g = (int'(c) >> 4) & 15;
    b = int'(c) & 15;
    return 12'(((r / 2) << 8) | ((g / 2) << 4) | (b / 2));
  endfunction

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic pop_check;
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("blood_on(%0d,%0d)", e.px, e.py), 32'(blood_on), 32'(e.on));
      chk($sformatf("color_out(%0d,%0d)", e.px, e.py), 32'(color_out), 32'(e.col));
    end
  endtask

  // One pixel: address for this pixel, ROM data for the previous one.
  task automatic pix(input int px, input int py, input bit vo, input logic [11:0] rom);
    exp_t e;
    bit   iw;
    x        = 10'(px);
    y        = 10'(py);
    video_on = vo;
    color_in = pend;
    #1;
    iw = (px >= org_x) && (px < org_x + 64) && (py >= org_y) && (py < org_y + 64);
    if (iw) begin
      chk($sformatf("rom_col(%0d)", px), 32'(rom_col), 32'(px - org_x));
      chk($sformatf("rom_row(%0d)", py), 32'(rom_row), 32'(py - org_y));
    end
    pop_check();
    e.px = px;
    e.py = py;
    e.on = vo && iw && exp_busy && (rom != 12'h000);
`ifdef BLOOD_FADE_EN
    e.col = !e.on ? 12'h000 : (exp_hold ? dim(rom) : rom);
`else
    e.col = e.on ? rom : 12'h000;
`endif
    sb.push_back(e);
    pend = rom;
    cyc();
  endtask

  task automatic flush;
    video_on = 1'b0;
    color_in = pend;
    #1;
    pop_check();
    pend = 12'h000;
    cyc();
  endtask

  task automatic trig(input int hx, input int hy, input bit with_tick);
    hit_x      = 10'(hx);
    hit_y      = 10'(hy);
    trigger    = 1'b1;
    frame_tick = with_tick;
    cyc();
    trigger    = 1'b0;
    frame_tick = 1'b0;
    org_x      = hx;
    org_y      = hy;
    exp_busy   = 1'b1;
    exp_hold   = 1'b0;
  endtask

  task automatic tick;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trigger = 1'b0; frame_tick = 1'b0; video_on = 1'b0;
    hit_x = '0; hit_y = '0; x = '0; y = '0; color_in = '0;
    repeat (3) cyc();

    // Reset state, with a trigger arriving during reset that must be ignored
    chk("rst_frame_sel", 32'(frame_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_blood_on", 32'(blood_on), 0);
    chk("rst_color_out", 32'(color_out), 0);
    hit_x = 10'd10; hit_y = 10'd10; trigger = 1'b1;
    cyc();
    trigger = 1'b0; reset = 1'b0;
    cyc();
    chk("trig_in_reset_busy", 32'(busy), 0);

    // Idle scan: nothing is drawn
    for (int i = 100; i < 104; i++) pix(i, 100, 1'b1, 12'hE00);
    flush();
    chk("idle_frame_sel", 32'(frame_sel), 0);

    // Start at (200,150) and scan across the sprite row
    trig(200, 150, 1'b0);
    chk("start_busy", 32'(busy), 1);
    chk("start_frame_sel", 32'(frame_sel), 0);
    for (int i = 199; i <= 264; i++) pix(i, 150, 1'b1, 12'hE00);
    flush();

    // Transparent pixels and video-off pixels inside the window
    pix(210, 150, 1'b1, 12'h000);
    pix(211, 150, 1'b1, 12'h000);
    pix(212, 150, 1'b0, 12'hE00);
    pix(213, 151, 1'b1, 12'h0F0);
    flush();

    // Frame stepping: two ticks per frame
    tick();
    chk("frame_after_1tick", 32'(frame_sel), 0);
    tick();
    chk("frame_after_2tick", 32'(frame_sel), 1);
    for (int i = 0; i < 46; i++) tick();
    chk("frame_after_48tick", 32'(frame_sel), 24);
    tick();
    tick();
    exp_hold = 1'b1;
    chk("hold_frame_sel", 32'(frame_sel), 24);
    chk("hold_busy", 32'(busy), 1);

    // Colour during hold (dimmed only with the fade option)
    pix(205, 155, 1'b1, 12'hE84);
    flush();

    for (int i = 0; i < 29; i++) begin
      tick();
      chk($sformatf("hold_done_%0d", i), 32'(done), 0);
    end
    tick();
    exp_busy = 1'b0;
    exp_hold = 1'b0;
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_frame_sel", 32'(frame_sel), 0);
    cyc();
    chk("end_done_once", 32'(done), 0);

    // Retrigger in the middle of the animation
    trig(200, 150, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("frame_10", 32'(frame_sel), 10);
    trig(50, 60, 1'b0);
    chk("retrig_frame_sel", 32'(frame_sel), 0);
    chk("retrig_busy", 32'(busy), 1);
    for (int i = 49; i <= 51; i++) pix(i, 60, 1'b1, 12'hE00);
    flush();
    tick();
    chk("retrig_tick1", 32'(frame_sel), 0);
    tick();
    chk("retrig_tick2", 32'(frame_sel), 1);

    // Trigger and frame_tick together: tick is dropped
    tick();
    trig(300, 200, 1'b1);
    chk("trig_tick_frame_sel", 32'(frame_sel), 0);
    tick();
    chk("trig_tick_next1", 32'(frame_sel), 0);
    tick();
    chk("trig_tick_next2", 32'(frame_sel), 1);

    // Screen-edge origin clips without wrapping
    trig(620, 470, 1'b0);
    for (int i = 616; i <= 639; i++) pix(i, 470, 1'b1, 12'h0A5);
    flush();
    for (int j = 468; j <= 479; j++) pix(620, j, 1'b1, 12'h0A5);
    flush();
    for (int i = 0; i < 4; i++) pix(i, 470, 1'b1, 12'h0A5);
    pix(620, 0, 1'b1, 12'h0A5);
    pix(620, 1, 1'b1, 12'h0A5);
    flush();

    // Reset while holding the last frame
    for (int i = 0; i < 50; i++) tick();
    chk("pre_reset_busy", 32'(busy), 1);
    chk("pre_reset_frame_sel", 32'(frame_sel), 24);
    reset = 1'b1;
    cyc();
    exp_busy = 1'b0;
    chk("reset_hold_busy", 32'(busy), 0);
    chk("reset_hold_frame_sel", 32'(frame_sel), 0);
    chk("reset_hold_done", 32'(done), 0);
    reset = 1'b0;
    cyc();
    chk("post_reset_done", 32'(done), 0);
    chk("post_reset_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
